// File: rtl/serializer_stream_if.sv
// rtl/serializer_stream_if.sv - word input and serial output bundle for serializer_stream
interface serializer_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic                  dout;
  logic                  dout_valid;
  logic                  word_start;

  // Producer side: drives words in and watches the serial line
  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, word_start
  );

  // Serializer side
  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, word_start
  );
endinterface

// File: rtl/serializer_stream.sv
// rtl/serializer_stream.sv - parallel-to-serial converter with one-word holding register
module serializer_stream #(
  parameter int       DATA_WIDTH = 8,
  parameter bit       MSB_FIRST  = 1'b1,
  parameter logic     IDLE_VAL   = 1'b0,
  parameter int       CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serializer_stream_if.slave   s,
  input  logic                 enable,
  input  logic                 clr_underrun,
  output logic                 busy,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   word_start_q, word_start_d;
  logic                   underrun_q, underrun_d;
  logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;

  logic accept;
  logic last_bit;
  logic load;
  logic set_underrun;

  // Bit that leaves the line next from a given word image
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  // Word image after the head bit has been consumed
  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Next-state logic: accept into hold, load/shift/drain the shifter when enabled
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    word_start_d = word_start_q;
    word_cnt_d   = word_cnt_q;
    set_underrun = 1'b0;

    accept   = s.din_valid & ~hold_full_q;
    last_bit = (bit_cnt_q == BW'(DATA_WIDTH - 1));
    // hold_full blocks accept, so load and accept never coincide
    load     = enable & hold_full_q &
               ((state_q == S_IDLE) | ((state_q == S_SHIFT) & last_bit));

    if (accept) begin
      hold_d      = s.din;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_d      = advance(hold_q);
      dout_d       = head_bit(hold_q);
      hold_full_d  = 1'b0;
      bit_cnt_d    = '0;
      state_d      = S_SHIFT;
      word_start_d = 1'b1;
      dout_valid_d = 1'b1;
      word_cnt_d   = word_cnt_q + CNT_WIDTH'(1);
    end else if (enable && state_q == S_SHIFT) begin
      if (!last_bit) begin
        dout_d       = head_bit(shift_q);
        shift_d      = advance(shift_q);
        bit_cnt_d    = bit_cnt_q + BW'(1);
        word_start_d = 1'b0;
      end else begin
        // Word finished with nothing queued: the stream has a gap
        state_d      = S_IDLE;
        dout_d       = IDLE_VAL;
        dout_valid_d = 1'b0;
        word_start_d = 1'b0;
        set_underrun = 1'b1;
      end
    end

    // A set on the same edge as a clear must survive
    underrun_d = set_underrun | (underrun_q & ~clr_underrun);
  end

  // State and output registers, reset drops any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      dout_q       <= IDLE_VAL;
      dout_valid_q <= 1'b0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      word_start_q <= word_start_d;
      underrun_q   <= underrun_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign s.din_ready  = ~hold_full_q;
  assign s.dout       = dout_q;
  assign s.dout_valid = dout_valid_q;
  assign s.word_start = word_start_q;
  assign busy         = (state_q == S_SHIFT) | hold_full_q;
  assign underrun     = underrun_q;
  assign word_cnt     = word_cnt_q;

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
- Parametrised single-clock fabric parallel-to-serial converter; successor of the fixed 8-bit DDR serdes wrapper.
- Takes DATA_WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock.
- A one-word holding register lets back-to-back words stream with no gap.
- Adds selectable bit order, idle line level, word framing strobe, gap (underrun) detection and a word counter.
- Drives emulator link lanes in place of a primitive serdes where no CLKDIV domain exists.

Parameters:
- DATA_WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = din[DATA_WIDTH-1] leaves first (same order as existing D1=din[7] mapping); 0 = din[0] first.
- IDLE_VAL, 1'b0, dout level when no word is being shifted.
- CNT_WIDTH, 16, width of word_cnt.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-low.
- din  in  DATA_WIDTH  parallel word.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a word; equals ~hold_full.
- enable  in  1  shift enable; low freezes the shifter.
- dout  out  1  registered serial output.
- dout_valid  out  1  dout carries a data bit (state SHIFT).
- word_start  out  1  high while dout carries the first bit of a word.
- busy  out  1  state SHIFT or hold_full.
- underrun  out  1  sticky stream-gap flag.
- clr_underrun  in  1  synchronous clear of underrun.
- word_cnt  out  CNT_WIDTH  words loaded into the shifter, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst=0, async):
  - dout=IDLE_VAL; dout_valid=0; word_start=0; busy=0; underrun=0; word_cnt=0.
  - hold_full=0, so din_ready=1. State=IDLE, bit counter=0.
  - Reset mid-word discards the shifter and holding contents; no partial word is resumed.
- Accept: on a clock edge with din_valid & din_ready, din is captured into hold and hold_full is set.
  - Accept is independent of enable.
  - No accept while hold_full, so no accept/load collision occurs.
- Load event:
  - Occurs on an edge with enable=1 and hold_full=1, when state=IDLE or (state=SHIFT and bit counter=DATA_WIDTH-1).
  - Effects: shifter <= hold; hold_full <= 0; bit counter <= 0; state <= SHIFT.
  - dout <= first bit per MSB_FIRST; word_start <= 1; dout_valid <= 1; word_cnt <= word_cnt+1 (wraps).
- SHIFT state, enable=1, bit counter < DATA_WIDTH-1: dout <= next bit; bit counter +1; word_start <= 0.
- SHIFT state, enable=1, bit counter = DATA_WIDTH-1:
  - If hold_full: load event, giving a seamless next word.
  - Otherwise: state <= IDLE; dout <= IDLE_VAL; dout_valid <= 0; word_start <= 0; underrun <= 1.
- enable=0:
  - State, bit counter, dout, dout_valid and word_start hold their values (frozen, not reset).
  - Accepts still occur.
- Latency: word accepted at edge N with state IDLE and enable=1 gives its first bit on dout after edge N+1; each word then occupies exactly DATA_WIDTH enabled cycles.
- Streaming: a new word accepted at any point before the last bit of the current word gives a continuous bit stream.
- underrun:
  - Set only on the SHIFT→IDLE transition.
  - clr_underrun=1 clears it on the next edge; simultaneous set and clear → set wins.
- IDLE with enable=1 and hold empty: dout stays IDLE_VAL, no underrun.
- Implementation: state encoded 2 states; bit counter width $clog2(DATA_WIDTH); all outputs registered except din_ready and busy.

Test Plan:
- Reset: hold rst=0 with din_valid=1 → din_ready=1, dout=IDLE_VAL=0, word_cnt=0; release rst → first accept on next edge.
- Single word: DATA_WIDTH=8, MSB_FIRST=1, accept 0xA5 at edge N, enable=1 → dout 1,0,1,0,0,1,0,1 after edges N+1..N+8 with word_start only on the first bit; then dout=0, dout_valid=0, underrun=1, word_cnt=1.
- Back-to-back: feed 0x3C then 0xF0 with din_valid held high → 16 contiguous data bits 00111100 11110000, word_start on bits 1 and 9, underrun set only after bit 16, word_cnt=2.
- Bit order / width: DATA_WIDTH=10, MSB_FIRST=0, word 10'h201 → output 1,0,0,0,0,0,0,0,0,1.
- Freeze: drop enable after the 3rd bit of 0xA5 for 5 cycles → dout holds 1 (bit 3) and din_ready stays usable; resume → remaining bits 0,0,1,0,1 with no duplicate or lost bit.
- Reset mid-word and underrun clear: assert rst during bit 4 → immediate idle outputs, the following word starts cleanly. Assert clr_underrun on the same edge as a SHIFT→IDLE transition → underrun=1; assert it again alone → underrun=0.
- Counter wrap: CNT_WIDTH=2, send 5 words → word_cnt sequence 1,2,3,0,1.
